// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial word shifter with valid/ready intake
//
// Purpose:
//   Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit
//   per cycle on serial_out, qualified by serial_valid. A word offered during
//   the final bit of the current word is loaded on that edge, so consecutive
//   words stream with no idle cycle between them.
//
// Ports:
//   clock        in   1      sole clock, rising edge
//   reset        in   1      synchronous, active-high
//   data_in      in   WIDTH  parallel word to serialize
//   data_valid   in   1      data_in holds an offered word
//   data_ready   out  1      a word is accepted this cycle (from registered state)
//   serial_out   out  1      serial bit stream (registered)
//   serial_valid out  1      serial_out carries a payload bit (registered)
//   words_sent   out  8      count of fully shifted words, wraps at 256
//
// Configuration:
//   BIT_SERIALIZER_LSB_FIRST_EN  defined   -> data_in[0] emitted first
//                                undefined -> data_in[WIDTH-1] emitted first
//   Only bit order changes; timing, handshake and counting are identical.

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic [7:0]       words_sent
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic [7:0]       words_q, words_d;

  logic             transfer;
  logic [WIDTH-1:0] shreg_adv;

  // The bit currently on serial_out is always the "head" of the shift
  // register, so the head of a freshly loaded or advanced word is what gets
  // registered into serial_out on the same edge.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
`else
  assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
`endif

  // Ready only from registered state: idle, or presenting the last bit.
  assign data_ready = (state_q == IDLE) || (idx_q == LAST_IDX);
  assign transfer   = data_valid && data_ready;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shreg_d        = shreg_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    words_d        = words_q;

    case (state_q)
      IDLE: begin
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        if (transfer) begin
          state_d        = SHIFT;
          idx_d          = '0;
          shreg_d        = data_in;
          serial_out_d   = head_bit(data_in);
          serial_valid_d = 1'b1;
        end
      end

      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          // Last bit leaves on this edge whether or not a new word follows.
          words_d = words_q + 8'd1;
          if (transfer) begin
            idx_d          = '0;
            shreg_d        = data_in;
            serial_out_d   = head_bit(data_in);
            serial_valid_d = 1'b1;
          end else begin
            state_d        = IDLE;
            idx_d          = '0;
            shreg_d        = '0;
            serial_out_d   = 1'b0;
            serial_valid_d = 1'b0;
          end
        end else begin
          idx_d          = idx_q + 1'b1;
          shreg_d        = shreg_adv;
          serial_out_d   = head_bit(shreg_adv);
          serial_valid_d = 1'b1;
        end
      end

      default: begin
        state_d        = IDLE;
        idx_d          = '0;
        shreg_d        = '0;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      words_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shreg_q        <= shreg_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      words_q        <= words_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign words_sent   = words_q;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per word; legal range 2..32.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 data_in  input  WIDTH  parallel word to be serialized.
REQ-005 data_valid  input  1  data_in holds a word offered for transfer.
REQ-006 data_ready  output  1  block accepts a word this cycle.
REQ-007 serial_out  output  1  serial bit stream; drives the sequence detector's sequence_in.
REQ-008 serial_valid  output  1  serial_out carries a payload bit this cycle.
REQ-009 words_sent  output  8  count of fully shifted words; wraps modulo 256.

Function
REQ-010 Transfer SHALL occur on a rising edge where data_valid=1 and data_ready=1; no transfer otherwise.
REQ-011 FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-012 data_ready SHALL be 1 in IDLE, 1 in SHIFT when bit index = WIDTH-1, else 0; it SHALL depend only on registered state.
REQ-013 IDLE: on transfer -> SHIFT, word captured into shift register, bit index cleared to 0; no transfer -> stay IDLE.
REQ-014 SHIFT: bit index < WIDTH-1 -> increment index, advance shift register by one bit.
REQ-015 SHIFT with index = WIDTH-1: transfer -> reload new word, index = 0, remain SHIFT (zero-gap back-to-back); no transfer -> IDLE.
REQ-016 serial_out and serial_valid SHALL be registered; first bit of an accepted word SHALL appear in the cycle after the transfer edge (latency 1).
REQ-017 Each word SHALL occupy exactly WIDTH consecutive cycles with serial_valid=1.
REQ-018 In IDLE, serial_out SHALL be 0 and serial_valid SHALL be 0.
REQ-019 words_sent SHALL increment by 1 on the edge that completes the last bit of a word (leaving index WIDTH-1), including back-to-back reload; 255 -> 0.
REQ-020 data_in changes while not transferring SHALL have no effect on the shift register.
REQ-021 data_valid asserted while data_ready=0 SHALL be held by the source; block SHALL NOT drop or partially capture it.

Reset
REQ-022 reset=1 at a rising edge SHALL force state IDLE, bit index 0, shift register 0, serial_out 0, serial_valid 0, words_sent 0.
REQ-023 reset SHALL take priority over a simultaneous transfer; the offered word is discarded.
REQ-024 reset during SHIFT SHALL abort the word; partial word SHALL NOT count in words_sent.
REQ-025 data_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro BIT_SERIALIZER_LSB_FIRST_EN defined: bits SHALL be emitted data_in[0] first, data_in[WIDTH-1] last.
REQ-027 Macro BIT_SERIALIZER_LSB_FIRST_EN undefined: bits SHALL be emitted data_in[WIDTH-1] first, data_in[0] last.
REQ-028 Macro SHALL affect only bit order; timing, handshake and counting SHALL be identical in both builds.

Verification
REQ-029 Reset held 3 cycles, release, no valid -> data_ready=1, serial_out=0, serial_valid=0, words_sent=0 throughout.
REQ-030 WIDTH=8, MSB build, single word 8'hB4 -> serial_out 1,0,1,1,0,1,0,0 over 8 cycles starting 1 cycle after transfer, serial_valid high exactly those 8 cycles, words_sent=1, then IDLE.
REQ-031 Back-to-back 8'hFF then 8'h00 with data_valid held -> 16 contiguous valid cycles, 8 ones then 8 zeros, no gap, words_sent=2.
REQ-032 data_valid asserted mid-word with 8'h5A -> data_ready=0 until index 7, transfer on that edge, 8'h5A starts immediately after previous word's last bit.
REQ-033 reset asserted at 4th bit of 8'hC3 -> next cycle serial_valid=0, serial_out=0, words_sent unchanged at 0; following word serializes correctly.
REQ-034 Send 257 words with LSB build, word 8'h01 -> each emits 1 then seven 0s; words_sent reads 1 after the 257th (wrap).
